// File: rtl/fft_out_reorder_if.sv
// Beat-level bus for fft_out_reorder: upstream write strobe/data and the
// downstream valid/ready stream with its frame marker and overflow flag.
interface fft_out_reorder_if #(
  parameter int WIDTH      = 14,
  parameter int DATA_WIDTH = 16
);
  logic                    in_en;
  logic signed [WIDTH-1:0] din_re  [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] din_im  [0:DATA_WIDTH-1];
  logic                    out_ready;
  logic                    out_valid;
  logic                    out_last;
  logic signed [WIDTH-1:0] dout_re [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] dout_im [0:DATA_WIDTH-1];
  logic                    overflow;

  modport master (
    output in_en, din_re, din_im, out_ready,
    input  out_valid, out_last, dout_re, dout_im, overflow
  );

  modport slave (
    input  in_en, din_re, din_im, out_ready,
    output out_valid, out_last, dout_re, dout_im, overflow
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong frame buffer that presents FFT output beats in bit-reversed
// (or natural) sample order over a valid/ready stream.
module fft_out_reorder #(
  parameter int WIDTH      = 14,
  parameter int DATA_WIDTH = 16,
  parameter int BEATS      = 32,
  parameter int REORDER    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  fft_out_reorder_if.slave  bus
);

  localparam int LOGD = $clog2(DATA_WIDTH);
  localparam int LOGB = $clog2(BEATS);
  localparam int LOGN = LOGD + LOGB;
  localparam logic [LOGB-1:0] LAST_BEAT = LOGB'(BEATS - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [LOGB-1:0] r_wptr, w_wptr_nxt;
  logic [LOGB-1:0] r_rptr, w_rptr_nxt;
  logic            r_wbank, w_wbank_nxt;
  logic            r_rbank, w_rbank_nxt;
  logic [1:0]      r_full, w_full_nxt, w_full_set, w_full_clr;
  logic            r_overflow, w_overflow_nxt;
  logic            w_wr, w_wr_last, w_rd_xfer, w_rd_last, w_valid;
  logic [LOGN-1:0] w_src [0:DATA_WIDTH-1];

  logic signed [WIDTH-1:0] r_mem_re [0:1][0:BEATS-1][0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] r_mem_im [0:1][0:BEATS-1][0:DATA_WIDTH-1];

  function automatic logic [LOGN-1:0] src_index(input logic [LOGB-1:0] beat,
                                                input logic [LOGD-1:0] lane);
    logic [LOGN-1:0] n;
    logic [LOGN-1:0] m;
    n = {beat, lane};
    m = n;
    if (REORDER != 0) begin
      for (int unsigned i = 0; i < LOGN; i++) m[i] = n[LOGN-1-i];
    end
    return m;
  endfunction

  always_comb begin
    w_wr      = bus.in_en && !r_full[r_wbank];
    w_wr_last = w_wr && (r_wptr == LAST_BEAT);
    w_rd_xfer = (r_state == S_DRAIN) && bus.out_ready;
    w_rd_last = w_rd_xfer && (r_rptr == LAST_BEAT);

    w_full_set = '0;
    if (w_wr_last) w_full_set[r_wbank] = 1'b1;
    w_full_clr = '0;
    if (w_rd_last) w_full_clr[r_rbank] = 1'b1;
    // Set and clear always target different banks: a full read bank blocks writes into it.
    w_full_nxt = (r_full | w_full_set) & ~w_full_clr;

    w_wptr_nxt     = r_wptr;
    w_wbank_nxt    = r_wbank;
    w_overflow_nxt = r_overflow | (bus.in_en && r_full[r_wbank]);
    if (w_wr) begin
      if (w_wr_last) begin
        w_wptr_nxt  = '0;
        w_wbank_nxt = ~r_wbank;
      end else begin
        w_wptr_nxt = r_wptr + 1'b1;
      end
    end

    w_state_nxt = r_state;
    w_rptr_nxt  = r_rptr;
    w_rbank_nxt = r_rbank;
    case (r_state)
      S_IDLE: begin
        // Looking at the bank being completed this edge gives valid one cycle after the last write.
        if (r_full[r_rbank] || w_full_set[r_rbank]) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_rd_xfer) begin
          if (w_rd_last) begin
            w_rptr_nxt  = '0;
            w_rbank_nxt = ~r_rbank;
            if (!w_full_nxt[~r_rbank]) w_state_nxt = S_IDLE;
          end else begin
            w_rptr_nxt = r_rptr + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
      r_full     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_wbank    <= w_wbank_nxt;
      r_rbank    <= w_rbank_nxt;
      r_full     <= w_full_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int unsigned l = 0; l < DATA_WIDTH; l++) begin
        r_mem_re[r_wbank][r_wptr][l] <= bus.din_re[l];
        r_mem_im[r_wbank][r_wptr][l] <= bus.din_im[l];
      end
    end
  end

  always_comb begin
    w_valid       = (r_state == S_DRAIN);
    bus.out_valid = w_valid;
    bus.out_last  = w_valid && (r_rptr == LAST_BEAT);
    bus.overflow  = r_overflow;
    for (int unsigned l = 0; l < DATA_WIDTH; l++) begin
      w_src[l]       = src_index(r_rptr, LOGD'(l));
      bus.dout_re[l] = '0;
      bus.dout_im[l] = '0;
      if (w_valid) begin
        bus.dout_re[l] = r_mem_re[r_rbank][w_src[l][LOGN-1:LOGD]][w_src[l][LOGD-1:0]];
        bus.dout_im[l] = r_mem_im[r_rbank][w_src[l][LOGN-1:LOGD]][w_src[l][LOGD-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed scoreboard bench: a bit-reversing and a pass-through instance
// receive identical frames; every accepted beat is compared to queued expectations.
module tb_fft_out_reorder;
  localparam int W = 14;
  localparam int D = 16;
  localparam int B = 32;
  localparam int N = D * B;
  localparam int LOGN = 9;

  typedef logic [W*D-1:0] vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.WIDTH(W), .DATA_WIDTH(D)) ifr ();
  fft_out_reorder_if #(.WIDTH(W), .DATA_WIDTH(D)) ifp ();

  fft_out_reorder #(.WIDTH(W), .DATA_WIDTH(D), .BEATS(B), .REORDER(1)) u_dut (
    .clk(clk), .rstn(rstn), .bus(ifr));
  fft_out_reorder #(.WIDTH(W), .DATA_WIDTH(D), .BEATS(B), .REORDER(0)) u_pass (
    .clk(clk), .rstn(rstn), .bus(ifp));

  vec_t q_re[$], q_im[$], pq_re[$], pq_im[$];
  bit   q_last[$];
  logic signed [W-1:0] fr_re [0:N-1];
  logic signed [W-1:0] fr_im [0:N-1];
  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0;
  int low_cnt  = 0;

  task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int rev9(input int n);
    int r = 0;
    for (int i = 0; i < LOGN; i++) if (((n >> i) & 1) != 0) r = r | (1 << (LOGN - 1 - i));
    return r;
  endfunction

  function automatic vec_t get_re(input int which);
    vec_t v;
    for (int l = 0; l < D; l++) v[l*W +: W] = (which == 0) ? ifr.dout_re[l] : ifp.dout_re[l];
    return v;
  endfunction

  function automatic vec_t get_im(input int which);
    vec_t v;
    for (int l = 0; l < D; l++) v[l*W +: W] = (which == 0) ? ifr.dout_im[l] : ifp.dout_im[l];
    return v;
  endfunction

  task automatic set_rdy(input logic r);
    ifr.out_ready = r;
    ifp.out_ready = r;
  endtask

  task automatic set_in(input logic en, input int beat);
    ifr.in_en = en;
    ifp.in_en = en;
    for (int l = 0; l < D; l++) begin
      ifr.din_re[l] = fr_re[beat*D+l];
      ifr.din_im[l] = fr_im[beat*D+l];
      ifp.din_re[l] = fr_re[beat*D+l];
      ifp.din_im[l] = fr_im[beat*D+l];
    end
  endtask

  // Pops and compares one expected beat per handshake, then advances one clock.
  task automatic tick();
    if (ifr.out_valid !== 1'b1) low_cnt++;
    if (ifr.out_valid === 1'b1 && ifr.out_ready === 1'b1) begin
      xfer_cnt++;
      if (q_re.size() == 0 || pq_re.size() == 0) begin
        chk_int("unexpected_beat", 1, 0);
      end else begin
        chk_vec("rev_dout_re", get_re(0), q_re.pop_front());
        chk_vec("rev_dout_im", get_im(0), q_im.pop_front());
        chk_int("rev_out_last", int'(ifr.out_last), int'(q_last[0]));
        chk_int("pass_out_valid", int'(ifp.out_valid), 1);
        chk_vec("pass_dout_re", get_re(1), pq_re.pop_front());
        chk_vec("pass_dout_im", get_im(1), pq_im.pop_front());
        chk_int("pass_out_last", int'(ifp.out_last), int'(q_last.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic prep_frame(input int mode, input bit push);
    vec_t er, ei, pr, pi;
    int n, m;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        fr_re[i] = W'(i);
        fr_im[i] = W'(-i);
      end else begin
        fr_re[i] = W'($urandom);
        fr_im[i] = W'($urandom);
      end
    end
    if (mode == 1) begin
      fr_re[0]   = -14'sd8192;
      fr_re[N-1] = 14'sd8191;
      fr_im[0]   = 14'sd8191;
      fr_im[N-1] = -14'sd8192;
    end
    if (push) begin
      for (int k = 0; k < B; k++) begin
        for (int l = 0; l < D; l++) begin
          n = k * D + l;
          m = rev9(n);
          er[l*W +: W] = fr_re[m];
          ei[l*W +: W] = fr_im[m];
          pr[l*W +: W] = fr_re[n];
          pi[l*W +: W] = fr_im[n];
        end
        q_re.push_back(er);
        q_im.push_back(ei);
        pq_re.push_back(pr);
        pq_im.push_back(pi);
        q_last.push_back(k == B - 1);
      end
    end
  endtask

  task automatic drive_beats(input int first, input int count);
    for (int b = first; b < first + count; b++) begin
      set_in(1'b1, b);
      tick();
    end
    set_in(1'b0, 0);
  endtask

  task automatic drain(input bit toggle, input int budget, output int cycles, output int unstable);
    vec_t pre;
    logic v, rdy, pre_last;
    cycles   = 0;
    unstable = 0;
    while (q_re.size() > 0 && cycles < budget) begin
      rdy = toggle ? ((cycles % 2) == 0) : 1'b1;
      set_rdy(rdy);
      v        = ifr.out_valid;
      pre      = get_re(0);
      pre_last = ifr.out_last;
      tick();
      if (v && !rdy && (get_re(0) !== pre || ifr.out_last !== pre_last)) unstable++;
      cycles++;
    end
    chk_int("drain_queue_empty", q_re.size() + pq_re.size(), 0);
  endtask

  initial begin
    int cyc, unst;
    rstn = 1'b0;
    set_rdy(1'b0);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
    set_in(1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_int("reset_out_valid", int'(ifr.out_valid), 0);
    chk_int("reset_out_last", int'(ifr.out_last), 0);
    chk_int("reset_overflow", int'(ifr.overflow), 0);
    chk_vec("reset_dout_re", get_re(0), '0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Ramp frame, bit-reversed output, ready held high
    set_rdy(1'b1);
    prep_frame(0, 1'b1);
    drive_beats(0, 31);
    chk_int("valid_before_last_write", int'(ifr.out_valid), 0);
    drive_beats(31, 1);
    chk_int("valid_after_last_write", int'(ifr.out_valid), 1);
    chk_int("beat0_lane1", int'(ifr.dout_re[1]), 256);
    chk_int("beat0_lane2", int'(ifr.dout_re[2]), 128);
    chk_int("pass_beat0_lane5", int'(ifp.dout_re[5]), 5);
    drain(1'b0, 100, cyc, unst);
    chk_int("idle_out_valid", int'(ifr.out_valid), 0);
    chk_vec("idle_dout_re_zero", get_re(0), '0);
    chk_vec("idle_dout_im_zero", get_im(0), '0);

    // Random frame with full-scale extremes
    prep_frame(1, 1'b1);
    drive_beats(0, 32);
    chk_int("rev_min_re", int'(ifr.dout_re[0]), -8192);
    chk_int("pass_min_re", int'(ifp.dout_re[0]), -8192);
    chk_int("pass_max_im", int'(ifp.dout_im[0]), 8191);
    drain(1'b0, 100, cyc, unst);

    // Ready toggling during drain
    prep_frame(1, 1'b1);
    drive_beats(0, 32);
    xfer_cnt = 0;
    drain(1'b1, 200, cyc, unst);
    chk_int("toggle_transfers", xfer_cnt, 32);
    chk_int("toggle_cycles", cyc, 63);
    chk_int("toggle_stall_stable", unst, 0);

    // Two back-to-back frames
    set_rdy(1'b1);
    prep_frame(1, 1'b1);
    drive_beats(0, 32);
    xfer_cnt = 0;
    low_cnt  = 0;
    prep_frame(0, 1'b1);
    drive_beats(0, 32);
    drain(1'b0, 100, cyc, unst);
    chk_int("b2b_transfers", xfer_cnt, 64);
    chk_int("b2b_valid_gaps", low_cnt, 0);
    chk_int("b2b_overflow", int'(ifr.overflow), 0);

    // Downstream stalled across three frames: third is dropped
    set_rdy(1'b0);
    prep_frame(0, 1'b1);
    drive_beats(0, 32);
    prep_frame(1, 1'b1);
    drive_beats(0, 32);
    chk_int("ovf_after_two_frames", int'(ifr.overflow), 0);
    prep_frame(1, 1'b0);
    drive_beats(0, 1);
    chk_int("ovf_at_third_beat0", int'(ifr.overflow), 1);
    chk_int("pass_ovf_at_third_beat0", int'(ifp.overflow), 1);
    drive_beats(1, 31);
    xfer_cnt = 0;
    drain(1'b0, 200, cyc, unst);
    chk_int("ovf_drain_transfers", xfer_cnt, 64);
    chk_int("ovf_sticky", int'(ifr.overflow), 1);
    chk_int("ovf_idle_after_drain", int'(ifr.out_valid), 0);

    // Reset in the middle of a drain
    prep_frame(0, 1'b1);
    drive_beats(0, 32);
    set_rdy(1'b1);
    repeat (10) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk_int("midreset_out_valid", int'(ifr.out_valid), 0);
    chk_int("midreset_out_last", int'(ifr.out_last), 0);
    chk_int("midreset_overflow", int'(ifr.overflow), 0);
    chk_vec("midreset_dout_re", get_re(0), '0);
    q_re.delete();
    q_im.delete();
    pq_re.delete();
    pq_im.delete();
    q_last.delete();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk_int("post_reset_idle", int'(ifr.out_valid), 0);
    prep_frame(1, 1'b1);
    drive_beats(0, 32);
    chk_int("post_reset_valid", int'(ifr.out_valid), 1);
    xfer_cnt = 0;
    drain(1'b0, 100, cyc, unst);
    chk_int("post_reset_transfers", xfer_cnt, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
